mips_mc_controller: RTL and testbench

- Main control FSM for the 8-bit multicycle MIPS datapath.
- Sequences instruction fetch (four byte-wide IR loads), decode, execute, memory and writeback states.
- Drives the 2-bit aluop that the ALU-control decoder combines with funct to form alucont.
- Also drives every mux select and write enable in the datapath: PC, IR, register file and memory.

---
 rtl/mips_mc_controller_if.sv | 31 +++
 rtl/mips_mc_controller.sv | 142 ++++++++++++++
 tb/tb_mips_mc_controller.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/mips_mc_controller_if.sv
// Control bundle between the multicycle MIPS controller and its datapath.
// The controller takes the master side; the datapath takes the slave side.
interface mips_mc_controller_if;
  logic [5:0] op;
  logic       zero;
  logic       memread;
  logic       memwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic       memtoreg;
  logic       iord;
  logic       regwrite;
  logic       regdst;
  logic       pcen;
  logic [1:0] pcsource;
  logic [1:0] aluop;
  logic [3:0] irwrite;
  logic [3:0] state;

  modport master (
    input  op, zero,
    output memread, memwrite, alusrca, alusrcb, memtoreg, iord, regwrite,
           regdst, pcen, pcsource, aluop, irwrite, state
  );

  modport slave (
    output op, zero,
    input  memread, memwrite, alusrca, alusrcb, memtoreg, iord, regwrite,
           regdst, pcen, pcsource, aluop, irwrite, state
  );
endinterface

// File: rtl/mips_mc_controller.sv
// Main Moore control FSM of the 8-bit multicycle MIPS: four byte fetches,
// decode, then per-opcode execute/memory/writeback states.
module mips_mc_controller #(
  parameter logic [5:0] OP_LB    = 6'b100000,
  parameter logic [5:0] OP_SB    = 6'b101000,
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_J     = 6'b000010,
  parameter logic [5:0] OP_ADDI  = 6'b001000
) (
  input logic                  clk,
  input logic                  reset,
  mips_mc_controller_if.master ctl
);

  typedef enum logic [3:0] {
    S_FETCH1  = 4'd0,
    S_FETCH2  = 4'd1,
    S_FETCH3  = 4'd2,
    S_FETCH4  = 4'd3,
    S_DECODE  = 4'd4,
    S_MEMADR  = 4'd5,
    S_LBRD    = 4'd6,
    S_LBWR    = 4'd7,
    S_SBWR    = 4'd8,
    S_RTYPEEX = 4'd9,
    S_RTYPEWR = 4'd10,
    S_BEQEX   = 4'd11,
    S_JEX     = 4'd12,
    S_ADDIEX  = 4'd13,
    S_ADDIWR  = 4'd14
  } state_e;

  state_e     state_q, state_d;
  logic       memread_c, memwrite_c, alusrca_c, memtoreg_c, iord_c;
  logic       regwrite_c, regdst_c, pcwrite_c, branch_c;
  logic [1:0] alusrcb_c, pcsource_c, aluop_c;
  logic [3:0] irwrite_c;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH1;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = S_FETCH1;
    memread_c  = 1'b0;
    memwrite_c = 1'b0;
    alusrca_c  = 1'b0;
    alusrcb_c  = 2'b00;
    memtoreg_c = 1'b0;
    iord_c     = 1'b0;
    regwrite_c = 1'b0;
    regdst_c   = 1'b0;
    pcwrite_c  = 1'b0;
    branch_c   = 1'b0;
    pcsource_c = 2'b00;
    aluop_c    = 2'b00;
    irwrite_c  = 4'b0000;
    case (state_q)
      S_FETCH1, S_FETCH2, S_FETCH3, S_FETCH4: begin
        // PC advances by one byte per fetch cycle via ALU PC+1.
        memread_c = 1'b1;
        alusrcb_c = 2'b01;
        pcwrite_c = 1'b1;
        irwrite_c = 4'b0001 << state_q[1:0];
        state_d   = (state_q == S_FETCH4) ? S_DECODE : state_e'(state_q + 4'd1);
      end
      S_DECODE: begin
        alusrcb_c = 2'b11;
        case (ctl.op)
          OP_LB, OP_SB: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_J:         state_d = S_JEX;
          OP_ADDI:      state_d = S_ADDIEX;
          default:      state_d = S_FETCH1;
        endcase
      end
      S_MEMADR: begin
        alusrca_c = 1'b1;
        alusrcb_c = 2'b10;
        state_d   = (ctl.op == OP_LB) ? S_LBRD : S_SBWR;
      end
      S_LBRD: begin
        memread_c = 1'b1;
        iord_c    = 1'b1;
        state_d   = S_LBWR;
      end
      S_LBWR: begin
        regwrite_c = 1'b1;
        memtoreg_c = 1'b1;
      end
      S_SBWR: begin
        memwrite_c = 1'b1;
        iord_c     = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca_c = 1'b1;
        aluop_c   = 2'b10;
        state_d   = S_RTYPEWR;
      end
      S_RTYPEWR: begin
        regwrite_c = 1'b1;
        regdst_c   = 1'b1;
      end
      S_BEQEX: begin
        alusrca_c  = 1'b1;
        aluop_c    = 2'b01;
        pcsource_c = 2'b01;
        branch_c   = 1'b1;
      end
      S_JEX: begin
        pcwrite_c  = 1'b1;
        pcsource_c = 2'b10;
      end
      S_ADDIEX: begin
        alusrca_c = 1'b1;
        alusrcb_c = 2'b10;
        state_d   = S_ADDIWR;
      end
      S_ADDIWR: regwrite_c = 1'b1;
      default: state_d = S_FETCH1;
    endcase
  end

  // Write enables are gated by reset so no datapath state moves while held.
  assign ctl.pcen     = ~reset & (pcwrite_c | (branch_c & ctl.zero));
  assign ctl.irwrite  = reset ? 4'b0000 : irwrite_c;
  assign ctl.memwrite = ~reset & memwrite_c;
  assign ctl.regwrite = ~reset & regwrite_c;
  assign ctl.memread  = memread_c;
  assign ctl.alusrca  = alusrca_c;
  assign ctl.alusrcb  = alusrcb_c;
  assign ctl.memtoreg = memtoreg_c;
  assign ctl.iord     = iord_c;
  assign ctl.regdst   = regdst_c;
  assign ctl.pcsource = pcsource_c;
  assign ctl.aluop    = aluop_c;
  assign ctl.state    = state_q;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Scoreboard bench for mips_mc_controller: a per-instruction reference model
// queues the expected outputs of every cycle; a negedge monitor compares.
module tb_mips_mc_controller;
  typedef int iq_t[$];

  logic clk = 1'b0;
  logic reset = 1'b1;
  mips_mc_controller_if bus ();

  mips_mc_controller dut (
    .clk   (clk),
    .reset (reset),
    .ctl   (bus.master)
  );

  always #5 clk = ~clk;

  logic [21:0] exp_q[$];
  int checks = 0;
  int passed = 0;
  int cyc = 0;

  // Instruction class -> list of states visited, from FETCH1 onward.
  function automatic iq_t model_seq(input logic [5:0] o);
    iq_t s;
    s = '{0, 1, 2, 3, 4};
    case (o)
      6'b100000: begin s.push_back(5); s.push_back(6); s.push_back(7); end
      6'b101000: begin s.push_back(5); s.push_back(8); end
      6'b000000: begin s.push_back(9); s.push_back(10); end
      6'b000100: s.push_back(11);
      6'b000010: s.push_back(12);
      6'b001000: begin s.push_back(13); s.push_back(14); end
      default: ;
    endcase
    return s;
  endfunction

  function automatic logic [21:0] model_out(input int st, input logic z, input logic r);
    logic mr, mw, asa, mtr, io, rw, rd, pcw, br;
    logic [1:0] asb, pcs, aop;
    logic [3:0] irw;
    logic pce;
    {mr, mw, asa, mtr, io, rw, rd, pcw, br} = '0;
    asb = 2'b00; pcs = 2'b00; aop = 2'b00; irw = 4'b0000;
    case (st)
      0, 1, 2, 3: begin mr = 1; asb = 2'b01; pcw = 1; irw = 4'(1 << st); end
      4:  asb = 2'b11;
      5:  begin asa = 1; asb = 2'b10; end
      6:  begin mr = 1; io = 1; end
      7:  begin rw = 1; mtr = 1; end
      8:  begin mw = 1; io = 1; end
      9:  begin asa = 1; aop = 2'b10; end
      10: begin rw = 1; rd = 1; end
      11: begin asa = 1; aop = 2'b01; pcs = 2'b01; br = 1; end
      12: begin pcw = 1; pcs = 2'b10; end
      13: begin asa = 1; asb = 2'b10; end
      14: rw = 1;
      default: ;
    endcase
    pce = pcw | (br & z);
    if (r) begin pce = 0; irw = 4'b0000; mw = 0; rw = 0; end
    return {4'(st), mr, mw, asa, asb, mtr, io, rw, rd, pce, pcs, aop, irw};
  endfunction

  // Hold reset for three edges starting in the cycle whose state is st.
  task automatic do_reset(input int st);
    reset = 1'b1;
    bus.zero = 1'($urandom_range(0, 1));
    exp_q.push_back(model_out(st, bus.zero, 1'b1));
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      exp_q.push_back(model_out(0, bus.zero, 1'b1));
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // zf: 0/1 forces zero, 2 randomizes it every cycle; rst_at: cycle index to reset at, -1 none.
  task automatic run_instr(input logic [5:0] o, input int zf, input int rst_at);
    iq_t seq;
    seq = model_seq(o);
    for (int i = 0; i < seq.size(); i++) begin
      if (i == rst_at) begin
        do_reset(seq[i]);
        return;
      end
      bus.op = o;
      bus.zero = (zf == 2) ? 1'($urandom_range(0, 1)) : (zf == 1);
      exp_q.push_back(model_out(seq[i], bus.zero, 1'b0));
      @(posedge clk); #1;
    end
  endtask

  always @(negedge clk) begin
    logic [21:0] act, e;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      act = {bus.state, bus.memread, bus.memwrite, bus.alusrca, bus.alusrcb,
             bus.memtoreg, bus.iord, bus.regwrite, bus.regdst, bus.pcen,
             bus.pcsource, bus.aluop, bus.irwrite};
      checks++;
      if (act === e) passed++;
      else $display("FAIL cyc%0d ctrl_vec state act=%0d exp=%0d vec act=%h exp=%h",
                    cyc, act[21:18], e[21:18], act, e);
    end
  end

  initial begin
    logic [5:0] legal[6];
    logic [5:0] o;
    legal = '{6'b100000, 6'b101000, 6'b000000, 6'b000100, 6'b000010, 6'b001000};
    bus.op = 6'b111111;
    bus.zero = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    exp_q.push_back(model_out(0, bus.zero, 1'b1));
    @(posedge clk); #1;
    reset = 1'b0;

    run_instr(6'b100000, 2, -1);
    run_instr(6'b000000, 2, -1);
    run_instr(6'b000100, 1, -1);
    run_instr(6'b000100, 0, -1);
    run_instr(6'b101000, 2, -1);
    run_instr(6'b000010, 2, -1);
    run_instr(6'b001000, 2, -1);
    run_instr(6'b111111, 2, -1);
    run_instr(6'b101000, 2, 6);
    run_instr(6'b100000, 2, -1);
    run_instr(6'b100000, 2, 6);

    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 6) == 0) begin
        do o = 6'($urandom); while (o inside {6'b100000, 6'b101000, 6'b000000,
                                              6'b000100, 6'b000010, 6'b001000});
      end else begin
        o = legal[$urandom_range(0, 5)];
      end
      run_instr(o, 2, -1);
    end

    @(posedge clk); #1;
    @(negedge clk); #1;
    checks++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL drain leftover=%0d required=0", exp_q.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
